// File: rtl/ibex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_wb_stage
//  Purpose  : Writeback stage. Holds one instruction after it leaves EX and
//             retires it. Non-LSU instructions retire one cycle after
//             capture. Loads and stores wait in WB until the LSU responds.
//  Ports    :
//    clk_i, rst_ni                    clock, asynchronous active-low reset
//    en_wb_i                          instruction enters WB this cycle
//    instr_type_wb_i                  0=ALU/multdiv 1=load 2=store 3=other
//    pc_id_i, instr_is_compressed_id_i
//    rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i   EX-side writeback request
//    lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i   LSU response
//    ready_wb_o                       WB can accept en_wb_i this cycle
//    rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o   register-file write port
//    pc_wb_o                          PC of the held instruction
//    outstanding_load_wb_o, outstanding_store_wb_o
//    instr_done_wb_o                  held instruction retires this cycle
//    perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
//  Revision : 1.0 - initial release
// ============================================================================
module ibex_wb_stage #(
    parameter bit PerfCounters = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        en_wb_i,
    input  logic [1:0]  instr_type_wb_i,
    input  logic [31:0] pc_id_i,
    input  logic        instr_is_compressed_id_i,
    input  logic [4:0]  rf_waddr_id_i,
    input  logic [31:0] rf_wdata_id_i,
    input  logic        rf_we_id_i,

    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] rf_wdata_lsu_i,

    output logic        ready_wb_o,
    output logic [4:0]  rf_waddr_wb_o,
    output logic [31:0] rf_wdata_wb_o,
    output logic        rf_we_wb_o,
    output logic [31:0] pc_wb_o,
    output logic        outstanding_load_wb_o,
    output logic        outstanding_store_wb_o,
    output logic        instr_done_wb_o,
    output logic        perf_instr_ret_wb_o,
    output logic        perf_instr_ret_compressed_wb_o
);

    localparam logic [1:0] c_type_load  = 2'd1;
    localparam logic [1:0] c_type_store = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_LSU = 2'd2
    } wb_state_e;

    wb_state_e   r_state;
    wb_state_e   w_state_next;

    logic [31:0] r_pc;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_compressed;
    logic [1:0]  r_type;

    logic        w_done;
    logic        w_ready;
    logic        w_capture;
    logic        w_held_load;
    logic        w_held_store;
    logic        w_err;
    logic        w_ret;

    // ------------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;

        case (r_state)
            ACTIVE:   w_done = 1'b1;
            WAIT_LSU: w_done = lsu_resp_valid_i;
            default:  w_done = 1'b0;
        endcase

        w_ready   = (r_state == IDLE) | w_done;
        // en_wb_i while not ready is dropped, so held state never changes.
        w_capture = en_wb_i & w_ready;

        if (w_capture) begin
            if ((instr_type_wb_i == c_type_load) || (instr_type_wb_i == c_type_store)) begin
                w_state_next = WAIT_LSU;
            end else begin
                w_state_next = ACTIVE;
            end
        end else if (w_done) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Captured instruction
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc         <= 32'd0;
            r_waddr      <= 5'd0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_compressed <= 1'b0;
            r_type       <= 2'd0;
        end else if (w_capture) begin
            r_pc         <= pc_id_i;
            r_waddr      <= rf_waddr_id_i;
            r_wdata      <= rf_wdata_id_i;
            r_we         <= rf_we_id_i;
            r_compressed <= instr_is_compressed_id_i;
            r_type       <= instr_type_wb_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Type is only meaningful while the instruction is still waiting;
    // after retirement r_type is stale.
    assign w_held_load  = (r_state == WAIT_LSU) & (r_type == c_type_load);
    assign w_held_store = (r_state == WAIT_LSU) & (r_type == c_type_store);
    // A bus error only counts against a load/store awaiting its response.
    assign w_err        = (r_state == WAIT_LSU) & lsu_resp_err_i;
    assign w_ret        = w_done & ~w_err;

    assign instr_done_wb_o        = w_done;
    assign ready_wb_o             = w_ready;
    assign pc_wb_o                = r_pc;
    assign rf_waddr_wb_o          = r_waddr;
    assign rf_wdata_wb_o          = w_held_load ? rf_wdata_lsu_i : r_wdata;
    assign rf_we_wb_o             = w_done & r_we & ~w_held_store & ~(w_held_load & lsu_resp_err_i);
    assign outstanding_load_wb_o  = w_held_load;
    assign outstanding_store_wb_o = w_held_store;

    generate
        if (PerfCounters) begin : g_perf
            assign perf_instr_ret_wb_o            = w_ret;
            assign perf_instr_ret_compressed_wb_o = w_ret & r_compressed;
        end else begin : g_no_perf
            assign perf_instr_ret_wb_o            = 1'b0;
            assign perf_instr_ret_compressed_wb_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibex_wb_stage
//  Purpose  : Self-checking bench for ibex_wb_stage. Expected retire records
//             are queued when an instruction is issued and compared when the
//             DUT signals instr_done_wb_o. A second instance with
//             PerfCounters=0 shares all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_wb_i;
    logic [1:0]  instr_type_wb_i;
    logic [31:0] pc_id_i;
    logic        instr_is_compressed_id_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic        rf_we_id_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [31:0] rf_wdata_lsu_i;

    logic        ready_wb_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic        rf_we_wb_o;
    logic [31:0] pc_wb_o;
    logic        outstanding_load_wb_o;
    logic        outstanding_store_wb_o;
    logic        instr_done_wb_o;
    logic        perf_instr_ret_wb_o;
    logic        perf_instr_ret_compressed_wb_o;

    logic        ready_0;
    logic [4:0]  waddr_0;
    logic [31:0] wdata_0;
    logic        we_0;
    logic [31:0] pc_0;
    logic        ol_0;
    logic        os_0;
    logic        done_0;
    logic        perf_0;
    logic        perfc_0;

    always #5 clk_i = ~clk_i;

    ibex_wb_stage #(.PerfCounters(1'b1)) u_dut (
        .clk_i                          (clk_i),
        .rst_ni                         (rst_ni),
        .en_wb_i                        (en_wb_i),
        .instr_type_wb_i                (instr_type_wb_i),
        .pc_id_i                        (pc_id_i),
        .instr_is_compressed_id_i       (instr_is_compressed_id_i),
        .rf_waddr_id_i                  (rf_waddr_id_i),
        .rf_wdata_id_i                  (rf_wdata_id_i),
        .rf_we_id_i                     (rf_we_id_i),
        .lsu_resp_valid_i               (lsu_resp_valid_i),
        .lsu_resp_err_i                 (lsu_resp_err_i),
        .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
        .ready_wb_o                     (ready_wb_o),
        .rf_waddr_wb_o                  (rf_waddr_wb_o),
        .rf_wdata_wb_o                  (rf_wdata_wb_o),
        .rf_we_wb_o                     (rf_we_wb_o),
        .pc_wb_o                        (pc_wb_o),
        .outstanding_load_wb_o          (outstanding_load_wb_o),
        .outstanding_store_wb_o         (outstanding_store_wb_o),
        .instr_done_wb_o                (instr_done_wb_o),
        .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o)
    );

    ibex_wb_stage #(.PerfCounters(1'b0)) u_dut_noperf (
        .clk_i                          (clk_i),
        .rst_ni                         (rst_ni),
        .en_wb_i                        (en_wb_i),
        .instr_type_wb_i                (instr_type_wb_i),
        .pc_id_i                        (pc_id_i),
        .instr_is_compressed_id_i       (instr_is_compressed_id_i),
        .rf_waddr_id_i                  (rf_waddr_id_i),
        .rf_wdata_id_i                  (rf_wdata_id_i),
        .rf_we_id_i                     (rf_we_id_i),
        .lsu_resp_valid_i               (lsu_resp_valid_i),
        .lsu_resp_err_i                 (lsu_resp_err_i),
        .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
        .ready_wb_o                     (ready_0),
        .rf_waddr_wb_o                  (waddr_0),
        .rf_wdata_wb_o                  (wdata_0),
        .rf_we_wb_o                     (we_0),
        .pc_wb_o                        (pc_0),
        .outstanding_load_wb_o          (ol_0),
        .outstanding_store_wb_o         (os_0),
        .instr_done_wb_o                (done_0),
        .perf_instr_ret_wb_o            (perf_0),
        .perf_instr_ret_compressed_wb_o (perfc_0)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        perf;
        logic        perfc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        en_wb_i                  = 1'b0;
        instr_type_wb_i          = 2'd0;
        pc_id_i                  = 32'd0;
        instr_is_compressed_id_i = 1'b0;
        rf_waddr_id_i            = 5'd0;
        rf_wdata_id_i            = 32'd0;
        rf_we_id_i               = 1'b0;
        lsu_resp_valid_i         = 1'b0;
        lsu_resp_err_i           = 1'b0;
        rf_wdata_lsu_i           = 32'd0;
    endtask

    // Drive an instruction into WB and queue what it must retire with.
    task automatic issue(input logic [1:0] typ, input logic [31:0] pc, input logic comp,
                         input logic [4:0] waddr, input logic [31:0] wdata, input logic we,
                         input logic [31:0] load_data, input logic err);
        exp_t e;
        logic lsu;
        en_wb_i                  = 1'b1;
        instr_type_wb_i          = typ;
        pc_id_i                  = pc;
        instr_is_compressed_id_i = comp;
        rf_waddr_id_i            = waddr;
        rf_wdata_id_i            = wdata;
        rf_we_id_i               = we;
        lsu      = (typ == 2'd1) || (typ == 2'd2);
        e.pc     = pc;
        e.waddr  = waddr;
        e.wdata  = (typ == 2'd1) ? load_data : wdata;
        e.we     = we && (typ != 2'd2) && !((typ == 2'd1) && err);
        e.perf   = !(lsu && err);
        e.perfc  = !(lsu && err) && comp;
        sb.push_back(e);
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        lsu_resp_valid_i = 1'b1;
        rf_wdata_lsu_i   = data;
        lsu_resp_err_i   = err;
    endtask

    // One clock: check outputs at the falling edge, then advance past the
    // rising edge and return inputs to idle.
    task automatic tick(input logic exp_done, input logic exp_ready,
                        input logic exp_ol, input logic exp_os);
        exp_t e;
        @(negedge clk_i);
        chk("done",       instr_done_wb_o,        exp_done);
        chk("ready",      ready_wb_o,             exp_ready);
        chk("out_load",   outstanding_load_wb_o,  exp_ol);
        chk("out_store",  outstanding_store_wb_o, exp_os);
        chk("np_perf",    perf_0,                 1'b0);
        chk("np_perfc",   perfc_0,                1'b0);
        if (instr_done_wb_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ret_pc",    pc_wb_o,                        e.pc);
                chk("ret_waddr", rf_waddr_wb_o,                  e.waddr);
                chk("ret_wdata", rf_wdata_wb_o,                  e.wdata);
                chk("ret_we",    rf_we_wb_o,                     e.we);
                chk("ret_perf",  perf_instr_ret_wb_o,            e.perf);
                chk("ret_perfc", perf_instr_ret_compressed_wb_o, e.perfc);
            end
        end else begin
            chk("idle_we",   rf_we_wb_o,          1'b0);
            chk("idle_perf", perf_instr_ret_wb_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready_wb_o,                     1'b1);
        chk({tag, "_done"},  instr_done_wb_o,                1'b0);
        chk({tag, "_we"},    rf_we_wb_o,                     1'b0);
        chk({tag, "_waddr"}, rf_waddr_wb_o,                  5'd0);
        chk({tag, "_wdata"}, rf_wdata_wb_o,                  32'd0);
        chk({tag, "_pc"},    pc_wb_o,                        32'd0);
        chk({tag, "_ol"},    outstanding_load_wb_o,          1'b0);
        chk({tag, "_os"},    outstanding_store_wb_o,         1'b0);
        chk({tag, "_perf"},  perf_instr_ret_wb_o,            1'b0);
        chk({tag, "_perfc"}, perf_instr_ret_compressed_wb_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // ALU op retires one cycle after capture.
        issue(2'd0, 32'h0000_1000, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Load with a 3-cycle LSU wait.
        issue(2'd1, 32'h0000_1004, 1'b0, 5'd7, 32'hAAAA_5555, 1'b1, 32'h1234_5678, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        respond(32'h1234_5678, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Four back-to-back ALU ops, including type 3 and a write to x0.
        issue(2'd0, 32'h0000_2000, 1'b0, 5'd1, 32'h0000_0011, 1'b1, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'd3, 32'h0000_2004, 1'b0, 5'd2, 32'h0000_0022, 1'b0, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        issue(2'd0, 32'h0000_2008, 1'b0, 5'd0, 32'h0000_0033, 1'b1, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        issue(2'd0, 32'h0000_200C, 1'b0, 5'd31, 32'h0000_0044, 1'b1, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Load with a bus error: retires, but no write and no perf pulse.
        issue(2'd1, 32'h0000_3000, 1'b0, 5'd9, 32'h0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        respond(32'hBAD0_BAD0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Store: an illegal en_wb_i during the wait is ignored; the store
        // never writes even with we set.
        issue(2'd2, 32'h0000_4000, 1'b0, 5'd3, 32'h0000_0077, 1'b1, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        en_wb_i         = 1'b1;
        instr_type_wb_i = 2'd0;
        pc_id_i         = 32'hFFFF_FFF0;
        rf_waddr_id_i   = 5'd12;
        rf_wdata_id_i   = 32'h0BAD_F00D;
        rf_we_id_i      = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("illegal_en_pc",    pc_wb_o,       32'h0000_4000);
        chk("illegal_en_waddr", rf_waddr_wb_o, 5'd3);
        respond(32'h0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);

        // Stray LSU responses in IDLE and ACTIVE are ignored; an error
        // flag there does not suppress the ALU retire.
        respond(32'h5555_5555, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        issue(2'd0, 32'h0000_5000, 1'b1, 5'd4, 32'hCAFE_0001, 1'b1, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        respond(32'h6666_6666, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Compressed ALU op: both perf pulses (zero on the no-perf instance).
        issue(2'd0, 32'h0000_5002, 1'b1, 5'd6, 32'hCAFE_0002, 1'b1, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);

        // Store abandoned by reset mid-wait; a late response does nothing.
        issue(2'd2, 32'h0000_6000, 1'b0, 5'd8, 32'h0000_0088, 1'b0, 32'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        respond(32'h7777_7777, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("stale_pc", pc_wb_o, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
